// File: rtl/spi_ctrl_master.sv
// SPI initiator issuing one 16-bit register read/write frame (MSB first) per start.
// Supports all four CPOL/CPHA modes with an SCLK half-period of CLK_DIV enabled cycles.
module spi_ctrl_master #(
    parameter int CLK_DIV    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int REG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  ena,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  start,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [REG_WIDTH-1:0]  wdata,
    output logic                  busy,
    output logic                  done,
    output logic [REG_WIDTH-1:0]  rdata,
    output logic                  spi_cs_n,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [5:0]           edge_q, edge_d, edge_nxt;
    logic [15:0]          tx_q, tx_d, frame;
    logic [REG_WIDTH-1:0] rx_q, rx_d, rdata_q, rdata_d;
    logic                 cpol_q, cpol_d, cpha_q, cpha_d, rw_q, rw_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic                 cs_n_q, cs_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic                 tick;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        rw_d    = rw_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;

        frame = '0;
        frame[15] = rw;
        frame[8 +: ADDR_WIDTH] = addr;
        if (rw) frame[REG_WIDTH-1:0] = wdata;

        tick     = (cnt_q == CNT_MAX);
        edge_nxt = edge_q + 6'd1;

        if (state_q == IDLE) begin
            sclk_d = cpol;
            if (start) begin
                cpol_d  = cpol;
                cpha_d  = cpha;
                rw_d    = rw;
                busy_d  = 1'b1;
                cs_n_d  = 1'b0;
                cnt_d   = '0;
                edge_d  = '0;
                state_d = SETUP;
                // cpha=0 presents bit15 immediately; cpha=1 waits for the leading edge
                if (cpha) begin
                    mosi_d = 1'b0;
                    tx_d   = frame;
                end else begin
                    mosi_d = frame[15];
                    tx_d   = {frame[14:0], 1'b0};
                end
            end
        end else begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                edge_d = edge_nxt;
                case (state_q)
                    SETUP, SHIFT: begin
                        sclk_d = ~sclk_q;
                        // odd edges sample in cpha=0, even edges sample in cpha=1
                        if (edge_nxt[0] ^ cpha_q) begin
                            rx_d = {rx_q[REG_WIDTH-2:0], spi_miso};
                        end else if (cpha_q || edge_nxt <= 6'd30) begin
                            mosi_d = tx_q[15];
                            tx_d   = {tx_q[14:0], 1'b0};
                        end
                        state_d = (edge_nxt == 6'd32) ? HOLD : SHIFT;
                    end
                    HOLD: begin
                        cs_n_d  = 1'b1;
                        sclk_d  = cpol_q;
                        state_d = GAP;
                    end
                    default: begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                        if (!rw_q) rdata_d = rx_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            rw_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            rw_q    <= rw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign spi_cs_n = cs_n_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;
endmodule

// File: tb/tb_spi_ctrl_master.sv
// Bench for spi_ctrl_master: behavioural SPI target plus a scoreboard of expected
// frames/read data pushed at start and popped at done.
module tb_spi_ctrl_master;
    logic       clk = 1'b0;
    logic       rstb, ena, cpol, cpha, start, rw;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       busy, done;
    logic [7:0] rdata;
    logic       spi_cs_n, spi_clk, spi_mosi, spi_miso;

    spi_ctrl_master #(.CLK_DIV(4), .ADDR_WIDTH(4), .REG_WIDTH(8)) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .cpol(cpol), .cpha(cpha), .start(start),
        .rw(rw), .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Behavioural target: samples MOSI on its sampling edge, returns s_byte in the last 8 bits
    bit          m_cpol, m_cpha;
    logic [7:0]  s_byte;
    logic [15:0] s_rx = '0;
    int          s_cnt = 0;
    logic        sclk_prev = 1'b0;
    logic        cs_prev = 1'b1;
    always @(spi_clk or spi_cs_n) begin
        if (spi_cs_n !== 1'b0 || cs_prev !== 1'b0) s_cnt = 0;
        else if (spi_clk !== sclk_prev && ((spi_clk != m_cpol) ^ m_cpha)) begin
            s_rx  = {s_rx[14:0], spi_mosi};
            s_cnt = s_cnt + 1;
        end
        sclk_prev = spi_clk;
        cs_prev   = spi_cs_n;
    end
    assign spi_miso = (s_cnt >= 8 && s_cnt < 16) ? s_byte[15 - s_cnt] : 1'b0;

    int rise_cnt = 0, cs_falls = 0, done_cnt = 0;
    always @(posedge spi_clk) if (spi_cs_n === 1'b0) rise_cnt++;
    always @(negedge spi_cs_n) cs_falls++;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    typedef struct packed {
        logic [15:0] frame;
        logic [7:0]  rdata;
    } exp_t;
    exp_t       sb[$];
    exp_t       e;
    logic [7:0] mdl_rdata;
    int         t0, d_at, cs_at;
    bit         to;
    logic       sc, sm;

    task automatic launch(input bit pol, input bit pha, input bit r, input logic [3:0] a,
                          input logic [7:0] wd, input logic [7:0] sbyte);
        exp_t x;
        @(negedge clk);
        m_cpol = pol; m_cpha = pha; s_byte = sbyte;
        cpol = pol; cpha = pha; rw = r; addr = a; wdata = wd; start = 1'b1;
        t0 = cyc + 1;
        x.frame = {r, 3'b000, a, r ? wd : 8'h00};
        x.rdata = r ? mdl_rdata : sbyte;
        mdl_rdata = x.rdata;
        sb.push_back(x);
        @(negedge clk);
        start = 1'b0;
        // scramble inputs so only latched values can produce the right frame
        cpol = ~pol; cpha = ~pha; rw = ~r; addr = ~a; wdata = ~wd;
    endtask

    task automatic wait_done(input int budget, output int dat, output int csat, output bit tmo);
        logic prev_cs;
        dat = -1; csat = -1; tmo = 1'b1; prev_cs = spi_cs_n;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (spi_cs_n && !prev_cs && csat < 0) csat = cyc;
            prev_cs = spi_cs_n;
            if (done) begin
                dat = cyc; tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b want 1", spi_cs_n); end
        checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", spi_clk); end
        checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", spi_mosi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", rdata); end
        rstb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mode0_read();
        launch(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'hCA);
        wait_done(400, d_at, cs_at, to);
        e = sb.pop_front();
        checks++; if (to) begin errors++; $display("FAIL m0_read_timeout got no done want done"); end
        checks++; if (d_at - t0 != 136) begin errors++; $display("FAIL m0_read_done_time got %0d want 136", d_at - t0); end
        checks++; if (s_rx !== e.frame) begin errors++; $display("FAIL m0_read_frame got %h want %h", s_rx, e.frame); end
        checks++; if (rdata !== e.rdata) begin errors++; $display("FAIL m0_read_rdata got %h want %h", rdata, e.rdata); end
    endtask

    task automatic test_mode0_write();
        int r0;
        r0 = rise_cnt;
        launch(1'b0, 1'b0, 1'b1, 4'h3, 8'h3C, 8'h00);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_accept_busy got %b want 1", busy); end
        checks++; if (spi_cs_n !== 1'b0) begin errors++; $display("FAIL wr_accept_cs_n got %b want 0", spi_cs_n); end
        checks++; if (spi_mosi !== 1'b1) begin errors++; $display("FAIL wr_accept_mosi got %b want 1", spi_mosi); end
        wait_done(400, d_at, cs_at, to);
        e = sb.pop_front();
        checks++; if (to) begin errors++; $display("FAIL wr_timeout got no done want done"); end
        checks++; if (cs_at - t0 != 132) begin errors++; $display("FAIL wr_cs_low got %0d want 132", cs_at - t0); end
        checks++; if (d_at - t0 != 136) begin errors++; $display("FAIL wr_done_time got %0d want 136", d_at - t0); end
        checks++; if (rise_cnt - r0 != 16) begin errors++; $display("FAIL wr_rising_edges got %0d want 16", rise_cnt - r0); end
        checks++; if (s_rx !== e.frame) begin errors++; $display("FAIL wr_frame got %h want %h", s_rx, e.frame); end
        checks++; if (rdata !== e.rdata) begin errors++; $display("FAIL wr_rdata_kept got %h want %h", rdata, e.rdata); end
    endtask

    task automatic test_read_modes();
        bit         pol_t[3]  = '{1'b1, 1'b0, 1'b1};
        bit         pha_t[3]  = '{1'b1, 1'b1, 1'b0};
        logic [7:0] byte_t[3] = '{8'hA5, 8'h5A, 8'h5A};
        for (int m = 0; m < 3; m++) begin
            @(negedge clk);
            cpol = pol_t[m];
            repeat (2) @(negedge clk);
            checks++; if (spi_clk !== pol_t[m]) begin errors++; $display("FAIL mode%0d_idle_sclk got %b want %b", m, spi_clk, pol_t[m]); end
            launch(pol_t[m], pha_t[m], 1'b0, 4'h5 + 4'(m), 8'h00, byte_t[m]);
            wait_done(400, d_at, cs_at, to);
            e = sb.pop_front();
            checks++; if (to) begin errors++; $display("FAIL mode%0d_timeout got no done want done", m); end
            checks++; if (s_rx !== e.frame) begin errors++; $display("FAIL mode%0d_frame got %h want %h", m, s_rx, e.frame); end
            checks++; if (rdata !== e.rdata) begin errors++; $display("FAIL mode%0d_rdata got %h want %h", m, rdata, e.rdata); end
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = cs_falls;
        launch(1'b0, 1'b0, 1'b0, 4'h7, 8'h00, 8'h77);
        cpol = 1'b0; cpha = 1'b0; rw = 1'b0; addr = 4'h7; wdata = 8'h00; start = 1'b1;
        wait_done(400, d_at, cs_at, to);
        e = sb.pop_front();
        checks++; if (to) begin errors++; $display("FAIL b2b_timeout got no done want done"); end
        checks++; if (d_at - t0 != 136) begin errors++; $display("FAIL b2b_done_time got %0d want 136", d_at - t0); end
        checks++; if (cs_falls - c0 != 1) begin errors++; $display("FAIL b2b_one_frame got %0d want 1", cs_falls - c0); end
        checks++; if (rdata !== e.rdata) begin errors++; $display("FAIL b2b_rdata1 got %h want %h", rdata, e.rdata); end
        e.frame = 16'h0700; e.rdata = 8'h77;
        mdl_rdata = 8'h77;
        sb.push_back(e);
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (spi_cs_n !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got cs_n=%b busy=%b want cs_n=0 busy=1", spi_cs_n, busy); end
        checks++; if (cs_falls - c0 != 2) begin errors++; $display("FAIL b2b_second_frame got %0d want 2", cs_falls - c0); end
        wait_done(400, d_at, cs_at, to);
        e = sb.pop_front();
        checks++; if (d_at - t0 != 136) begin errors++; $display("FAIL b2b_done2_time got %0d want 136", d_at - t0); end
        checks++; if (s_rx !== e.frame) begin errors++; $display("FAIL b2b_frame2 got %h want %h", s_rx, e.frame); end
        checks++; if (rdata !== e.rdata) begin errors++; $display("FAIL b2b_rdata2 got %h want %h", rdata, e.rdata); end
    endtask

    task automatic test_reset_midframe();
        int d0;
        launch(1'b1, 1'b0, 1'b0, 4'h9, 8'h00, 8'h11);
        repeat (40) @(negedge clk);
        d0 = done_cnt;
        #2 rstb = 1'b0;
        #1;
        checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL rst_mid_cs_n got %b want 1", spi_cs_n); end
        checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL rst_mid_sclk got %b want 0", spi_clk); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        @(negedge clk);
        rstb = 1'b1;
        mdl_rdata = 8'h00;
        e = sb.pop_front();
        repeat (150) @(negedge clk);
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL rst_mid_no_done got %0d want %0d", done_cnt, d0); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_mid_rdata got %h want 00", rdata); end
        launch(1'b1, 1'b0, 1'b0, 4'h9, 8'h00, 8'h3E);
        wait_done(400, d_at, cs_at, to);
        e = sb.pop_front();
        checks++; if (d_at - t0 != 136) begin errors++; $display("FAIL rst_next_done_time got %0d want 136", d_at - t0); end
        checks++; if (s_rx !== e.frame) begin errors++; $display("FAIL rst_next_frame got %h want %h", s_rx, e.frame); end
        checks++; if (rdata !== e.rdata) begin errors++; $display("FAIL rst_next_rdata got %h want %h", rdata, e.rdata); end
    endtask

    task automatic test_ena_stall();
        launch(1'b0, 1'b0, 1'b1, 4'hC, 8'h96, 8'h00);
        fork
            wait_done(400, d_at, cs_at, to);
            begin
                repeat (40) @(negedge clk);
                ena = 1'b0;
                @(negedge clk);
                sc = spi_clk; sm = spi_mosi;
                repeat (19) @(negedge clk);
                checks++; if (spi_clk !== sc || spi_mosi !== sm) begin errors++; $display("FAIL stall_frozen got sclk=%b mosi=%b want sclk=%b mosi=%b", spi_clk, spi_mosi, sc, sm); end
                ena = 1'b1;
            end
        join
        e = sb.pop_front();
        checks++; if (to) begin errors++; $display("FAIL stall_timeout got no done want done"); end
        checks++; if (d_at - t0 != 156) begin errors++; $display("FAIL stall_done_time got %0d want 156", d_at - t0); end
        checks++; if (s_rx !== e.frame) begin errors++; $display("FAIL stall_frame got %h want %h", s_rx, e.frame); end
        checks++; if (rdata !== e.rdata) begin errors++; $display("FAIL stall_rdata got %h want %h", rdata, e.rdata); end
    endtask

    initial begin
        rstb = 1'b0; ena = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; rw = 1'b0;
        addr = 4'h0; wdata = 8'h00; m_cpol = 1'b0; m_cpha = 1'b0; s_byte = 8'h00; mdl_rdata = 8'h00;
        test_reset();
        test_mode0_read();
        test_mode0_write();
        test_read_modes();
        test_back_to_back();
        test_reset_midframe();
        test_ena_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_ctrl_master.md
Name: spi_ctrl_master

Overview:
- SPI controller (initiator) that issues single register read/write transactions to the SPI register peripheral.
- Used in chip-level test harnesses and in on-chip loopback: it drives cs_n/sclk/mosi and samples miso.
- Supports all four CPOL/CPHA modes and a programmable SCLK half-period.
- Each transaction is one fixed 16-bit frame, MSB first.

Parameters:
- CLK_DIV, 4, SCLK half-period in clk cycles (min 1; must be ≥4 when the target double-synchronises its inputs on the same clock).
- ADDR_WIDTH, 4, register address width (≤7).
- REG_WIDTH, 8, data width (fixed 8; frame length is 16).

Ports:
- clk  input  1  system clock
- rstb  input  1  asynchronous active-low reset
- ena  input  1  clock enable; when 0, all state and outputs hold
- cpol  input  1  SCLK idle level; latched at start
- cpha  input  1  0: sample on leading edge, 1: sample on trailing edge; latched at start
- start  input  1  transaction request; accepted only in IDLE
- rw  input  1  1=write, 0=read; latched at start
- addr  input  ADDR_WIDTH  register address; latched at start
- wdata  input  REG_WIDTH  write data; latched at start
- busy  output  1  high from the accept cycle until done
- done  output  1  one-cycle pulse at transaction end
- rdata  output  REG_WIDTH  read data; valid from done, held until next read's done
- spi_cs_n  output  1  chip select, active low
- spi_clk  output  1  SCLK
- spi_mosi  output  1  serial data out
- spi_miso  input  1  serial data in

Behaviour:
- Reset values: spi_cs_n=1, spi_clk=0, spi_mosi=0, busy=0, done=0, rdata=0, state=IDLE. Async assertion forces these immediately, including mid-frame (no completion, no done).
- Frame: bit15=rw, bits14..ADDR_WIDTH+8 = 0, next ADDR_WIDTH bits = addr, bits7..0 = wdata for writes, 0x00 for reads. Transmitted MSB first.
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE: spi_clk follows cpol each enabled cycle; spi_cs_n=1.
  - start=1 at edge T0: latch the frame, cpol, cpha; set busy=1; spi_cs_n=0 at T0.
  - cpha=0: spi_mosi=bit15 at T0. cpha=1: spi_mosi=0 until edge 1.
- Half-period counter counts CLK_DIV enabled cycles. SCLK edge k (k=1..32) occurs at T0+k·CLK_DIV; each edge toggles spi_clk. Odd k = leading edge, even k = trailing edge.
- SETUP covers T0 to edge 1; SHIFT covers edges 1..32.
- cpha=0:
  - Sample spi_miso on odd edges.
  - Shift the next MOSI bit on even edges 2..30.
  - spi_mosi holds bit0 after edge 32.
- cpha=1:
  - Present the next MOSI bit on odd edges.
  - Sample on even edges.
- Sampling registers spi_miso on the same clk edge that toggles spi_clk.
- Received bits 7..0 are the last 8 samples. rdata is updated at done, for reads only; writes leave rdata unchanged.
- HOLD: after edge 32, spi_clk=cpol; spi_cs_n stays 0 for CLK_DIV cycles. spi_cs_n=1 at T0+33·CLK_DIV.
- GAP: CLK_DIV cycles with spi_cs_n=1. At T0+34·CLK_DIV: done=1 for one cycle, busy=0, state=IDLE.
- Total busy time = 34·CLK_DIV cycles. Earliest next start is the cycle after done.
- start while busy is ignored; no queuing.
- cpol, cpha, rw, addr and wdata changes during busy have no effect.
- ena=0: counter, FSM and all outputs freeze; with ena=0 for N cycles, timing extends by exactly N.
- CLK_DIV=1: SCLK toggles every cycle; the same edge rules apply.

Test Plan:
- Mode 0, CLK_DIV=4, write addr=0x3, wdata=0x3C → MOSI bits 0x833C captured on rising SCLK; 16 rising edges; cs_n low 132 cycles; done at cycle 136; rdata unchanged.
- Mode 0 read addr=0x0, behavioural slave returns 0xCA → MOSI frame 0x0000; done pulse; rdata=0xCA.
- Mode 3 (cpol=1, cpha=1) read, slave returns 0xA5 → SCLK idles high; samples on rising (trailing) edges; rdata=0xA5. Repeat for modes 1 and 2 with 0x5A.
- start re-asserted on every cycle while busy → exactly one frame; a second frame begins only at the cycle after done.
- rstb pulsed low at SCLK edge 10 → spi_cs_n=1, spi_clk=0, busy=0 immediately; no done; the next start runs a full, correct frame.
- ena held low for 20 cycles mid-SHIFT → SCLK and MOSI frozen; done arrives 20 cycles later than nominal; data intact.
